// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed-latency registered response,
// RISC-V byte/half/word access with lane writes, load extension and error checks.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned LAST = (LATENCY >= 2) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;

  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_funct3;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;

  logic          w_accept;
  logic          w_exec;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [2:0]    w_funct3;
  logic [31:0]   w_off;
  logic [1:0]    w_lane;
  logic [IW-1:0] w_idx;
  logic          w_range_err;
  logic          w_f3_err;
  logic          w_align_err;
  logic          w_err;
  logic [3:0]    w_be_base;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_sh;
  logic [31:0]   w_rword;
  logic [31:0]   w_rsh;
  logic [31:0]   w_load;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // With single-cycle latency the access happens on the accept edge itself,
  // so it must use the live request rather than the captured copy.
  assign w_we     = (LATENCY == 1) ? req_we     : r_we;
  assign w_addr   = (LATENCY == 1) ? req_addr   : r_addr;
  assign w_wdata  = (LATENCY == 1) ? req_wdata  : r_wdata;
  assign w_funct3 = (LATENCY == 1) ? req_funct3 : r_funct3;
  assign w_exec   = (LATENCY == 1) ? w_accept
                                   : ((r_state == S_WAIT) && (r_cnt == CW'(LAST)));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CW'(LAST)) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latency counter and request capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + CW'(1) : '0;
      if (w_accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
      end
    end
  end

  assign w_off       = w_addr - BASE_ADDR;
  assign w_lane      = w_off[1:0];
  assign w_idx       = w_off[IW+1:2];
  assign w_range_err = (w_addr < BASE_ADDR) || (|w_off[31:IW+2]);

  // Access-type decode: lane mask at lane 0 and alignment per size
  always_comb begin
    w_be_base   = 4'b0000;
    w_f3_err    = 1'b0;
    w_align_err = 1'b0;
    case (w_funct3)
      3'b000, 3'b100: w_be_base = 4'b0001;
      3'b001, 3'b101: begin
        w_be_base   = 4'b0011;
        w_align_err = w_lane[0];
      end
      3'b010: begin
        w_be_base   = 4'b1111;
        w_align_err = (w_lane != 2'b00);
      end
      default: w_f3_err = 1'b1;
    endcase
  end

  assign w_err      = w_range_err || w_f3_err || w_align_err || (w_we && w_funct3[2]);
  assign w_be       = w_be_base << w_lane;
  assign w_wdata_sh = w_wdata << {w_lane, 3'b000};
  assign w_rword    = r_mem[w_idx];
  assign w_rsh      = w_rword >> {w_lane, 3'b000};

  always_comb begin
    w_load = '0;
    case (w_funct3)
      3'b000:  w_load = {{24{w_rsh[7]}}, w_rsh[7:0]};
      3'b100:  w_load = {24'd0, w_rsh[7:0]};
      3'b001:  w_load = {{16{w_rsh[15]}}, w_rsh[15:0]};
      3'b101:  w_load = {16'd0, w_rsh[15:0]};
      3'b010:  w_load = w_rword;
      default: w_load = '0;
    endcase
  end

  // Storage array; only error-free stores commit, lane by lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_exec && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // Response registers: one pulse, data zero unless a clean load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_exec;
      r_resp_err   <= w_exec && w_err;
      r_resp_rdata <= (w_exec && !w_err && !w_we) ? w_load : '0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance checked against
// a byte-array reference model with directed and random load/store traffic.
module tb_dmem_responder;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][2:0]  req_funct3;
  logic [1:0]       resp_valid;
  logic [1:0][31:0] resp_rdata;
  logic [1:0]       resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc [2];

  logic [7:0] mb [2][1024];

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) mb[d][i] = 8'h00;
  endfunction

  // Reference: memory as a flat little-endian byte array
  function automatic void model(input int d, input logic we, input logic [31:0] addr,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic [31:0] r, output logic e);
    int size;
    bit sgn;
    logic [31:0] v;
    size = 0;
    sgn  = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    r = 32'd0;
    e = 1'b0;
    if (size == 0) e = 1'b1;
    else if (addr >= 32'd1024) e = 1'b1;
    else if (we && (f3 == 3'd4 || f3 == 3'd5)) e = 1'b1;
    else if ((addr % size) != 0) e = 1'b1;
    if (e) return;
    if (we) begin
      for (int i = 0; i < size; i++) mb[d][int'(addr) + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[d][int'(addr) + i];
      if (sgn && size < 4 && v[8*size-1]) begin
        for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
      end
      r = v;
    end
  endfunction

  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wd, input string name);
    int lat;
    int n;
    logic [31:0] er;
    logic ex;
    logic [31:0] got_d;
    logic got_e;
    lat   = (d == 0) ? 2 : 1;
    got_d = 32'hx;
    got_e = 1'bx;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_funct3[d] = f3; req_wdata[d] = wd;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      n_fail++;
      $display("FAIL %s_ready_timeout: req_ready=%b required 1", name, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    model(d, we, addr, f3, wd, er, ex);
    acc_cyc[d] = cyc;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_funct3[d] = 3'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_ready_c%0d: req_ready=%b required 0", name, k, req_ready[d]);
      end
      n_checks++;
      if (resp_valid[d] !== 1'(k == lat)) begin
        n_fail++;
        $display("FAIL %s_valid_c%0d: resp_valid=%b required %b", name, k, resp_valid[d], k == lat);
      end
      if (k == lat) begin
        got_d = resp_rdata[d];
        got_e = resp_err[d];
      end
    end
    n_checks++;
    if (got_d !== er) begin
      n_fail++;
      $display("FAIL %s_rdata: got %h required %h", name, got_d, er);
    end
    n_checks++;
    if (got_e !== ex) begin
      n_fail++;
      $display("FAIL %s_err: got %b required %b", name, got_e, ex);
    end
  endtask

  task automatic check_idle(input int d, input string name);
    n_checks++;
    if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
               name, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_idle(0, "reset_idle_l2");
    check_idle(1, "reset_idle_l1");
    rst = 1'b1;
  endtask

  task automatic test_first_load();
    txn(0, 1'b0, 32'h10, 3'b010, 32'h0, "first_lw");
    txn(1, 1'b0, 32'h10, 3'b010, 32'h0, "first_lw_l1");
  endtask

  task automatic test_store_load();
    int a1;
    txn(0, 1'b1, 32'h20, 3'b010, 32'hDEADBEEF, "sw_20");
    a1 = acc_cyc[0];
    txn(0, 1'b0, 32'h20, 3'b010, 32'h0, "lw_20");
    n_checks++;
    if (acc_cyc[0] - a1 !== 3) begin
      n_fail++;
      $display("FAIL accept_spacing_l2: got %0d cycles required 3", acc_cyc[0] - a1);
    end
  endtask

  task automatic test_byte_lanes();
    txn(0, 1'b1, 32'h21, 3'b000, 32'hFFFFFF80, "sb_21");
    txn(0, 1'b0, 32'h21, 3'b000, 32'h0, "lb_21");
    txn(0, 1'b0, 32'h21, 3'b100, 32'h0, "lbu_21");
    txn(0, 1'b0, 32'h20, 3'b010, 32'h0, "lw_20_merged");
    txn(0, 1'b1, 32'h22, 3'b001, 32'h00018001, "sh_22");
    txn(0, 1'b0, 32'h22, 3'b001, 32'h0, "lh_22");
    txn(0, 1'b0, 32'h22, 3'b101, 32'h0, "lhu_22");
    txn(0, 1'b0, 32'h20, 3'b010, 32'h0, "lw_20_half");
  endtask

  task automatic test_errors();
    txn(0, 1'b1, 32'h0,   3'b010, 32'h12345678, "sw_0");
    txn(0, 1'b0, 32'h23,  3'b001, 32'h0, "lh_misalign");
    txn(0, 1'b1, 32'h400, 3'b010, 32'hFFFFFFFF, "sw_range");
    txn(0, 1'b0, 32'h0,   3'b010, 32'h0, "lw_0_after_range");
    txn(0, 1'b0, 32'h8,   3'b011, 32'h0, "bad_f3_011");
    txn(0, 1'b1, 32'h4,   3'b100, 32'hAA, "store_f3_100");
    txn(0, 1'b0, 32'h22,  3'b010, 32'h0, "lw_misalign");
    txn(0, 1'b0, 32'h3FC, 3'b010, 32'h0, "lw_top_word");
    txn(1, 1'b1, 32'h401, 3'b000, 32'h5A, "sb_range_l1");
    txn(1, 1'b0, 32'h21,  3'b001, 32'h0, "lh_misalign_l1");
    @(negedge clk);
    n_checks++;
    if (resp_valid[0] !== 1'b0 || resp_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_pulse_width: resp_valid=%b required 00", resp_valid);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
    req_funct3[0] = 3'b010; req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    #1;
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_in_reset_c%0d: resp_valid=%b required 0", k, resp_valid[0]);
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle(0, "abort_after_release");
    end
    txn(0, 1'b0, 32'h30, 3'b010, 32'h0, "abort_lw_30");
    txn(0, 1'b0, 32'h20, 3'b010, 32'h0, "abort_lw_20_cleared");
  endtask

  task automatic test_lat1_back_to_back();
    int a_prev;
    txn(1, 1'b1, 32'h40, 3'b010, 32'h0BADF00D, "l1_sw_40");
    for (int i = 0; i < 4; i++) begin
      a_prev = acc_cyc[1];
      if (i % 2 == 0) txn(1, 1'b0, 32'h40, 3'b010, 32'h0, "l1_lw_40");
      else txn(1, 1'b1, 32'h40 + 32'(i), 3'b000, 32'($urandom), "l1_sb_40");
      n_checks++;
      if (acc_cyc[1] - a_prev !== 2) begin
        n_fail++;
        $display("FAIL accept_spacing_l1: got %0d cycles required 2", acc_cyc[1] - a_prev);
      end
    end
  endtask

  task automatic test_random();
    int d;
    logic [31:0] a;
    for (int i = 0; i < 120; i++) begin
      d = int'($urandom_range(1, 0));
      a = ($urandom_range(7, 0) == 0) ? $urandom : 32'($urandom_range(63, 0));
      txn(d, 1'($urandom), a, 3'($urandom), $urandom, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_reset_abort();
    test_lat1_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
